// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - shared MIPS-subset opcode/funct map and descriptor types
//
// Purpose: op-class enum, opcode and funct constants, NOP word, descriptor
// struct and word-packing helpers shared by the encoder and the control decoder.
// Ports: none (package).

package isa_pkg;

  typedef enum logic [3:0] {
    OPC_ADD  = 4'h0,
    OPC_SUB  = 4'h1,
    OPC_AND  = 4'h2,
    OPC_OR   = 4'h3,
    OPC_XOR  = 4'h4,
    OPC_SLT  = 4'h5,
    OPC_SLL  = 4'h6,
    OPC_SRL  = 4'h7,
    OPC_LW   = 4'h8,
    OPC_SW   = 4'h9,
    OPC_BEQ  = 4'hA,
    OPC_BGT  = 4'hB,
    OPC_XORI = 4'hC,
    OPC_J    = 4'hD
  } op_class_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } enc_state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BGT   = 6'h05;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // op is raw 4 bits so the illegal codes E/F can be carried and detected.
  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] target;
  } desc_t;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] opcode, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opcode, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational descriptor-to-instruction-word packer
//
// Purpose: maps one decoded descriptor to its 32-bit encoding; illegal op
// classes produce the NOP word and raise illegal.
// Ports:
//   desc    in  descriptor (op class, register fields, imm, target)
//   word    out encoded instruction word
//   illegal out op class has no encoding

module instr_pack
  import isa_pkg::*;
(
  input  desc_t       desc,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = NOP_WORD;
    illegal = 1'b0;
    case (desc.op)
      OPC_ADD:  word = r_word(desc.rs, desc.rt, desc.rd, 5'd0, FN_ADD);
      OPC_SUB:  word = r_word(desc.rs, desc.rt, desc.rd, 5'd0, FN_SUB);
      OPC_AND:  word = r_word(desc.rs, desc.rt, desc.rd, 5'd0, FN_AND);
      OPC_OR:   word = r_word(desc.rs, desc.rt, desc.rd, 5'd0, FN_OR);
      OPC_XOR:  word = r_word(desc.rs, desc.rt, desc.rd, 5'd0, FN_XOR);
      OPC_SLT:  word = r_word(desc.rs, desc.rt, desc.rd, 5'd0, FN_SLT);
      // Shifts take their operand from rt; rs is forced to zero.
      OPC_SLL:  word = r_word(5'd0, desc.rt, desc.rd, desc.shamt, FN_SLL);
      OPC_SRL:  word = r_word(5'd0, desc.rt, desc.rd, desc.shamt, FN_SRL);
      OPC_LW:   word = i_word(OP_LW,   desc.rs, desc.rt, desc.imm);
      OPC_SW:   word = i_word(OP_SW,   desc.rs, desc.rt, desc.imm);
      OPC_BEQ:  word = i_word(OP_BEQ,  desc.rs, desc.rt, desc.imm);
      OPC_BGT:  word = i_word(OP_BGT,  desc.rs, desc.rt, desc.imm);
      OPC_XORI: word = i_word(OP_XORI, desc.rs, desc.rt, desc.imm);
      OPC_J:    word = {OP_J, desc.target};
      default: begin
        word    = NOP_WORD;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - streaming instruction encoder and program loader
//
// Purpose: accepts descriptors over valid/ready, packs them into words and
// writes them to consecutive instruction-memory addresses from BASE_ADDR.
// Optional feature macro: IENC_CKSUM_EN (running XOR checksum of written words).
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   start                         (re)arm loader at BASE_ADDR
//   in_valid/in_ready/in_last     descriptor handshake, end-of-program marker
//   in_op, in_rs, in_rt, in_rd,
//   in_shamt, in_imm, in_target   descriptor fields
//   imem_we/imem_addr/imem_wdata  instruction-memory write port
//   busy, done, err               LOAD state, DONE state, sticky illegal op
//   count, cksum                  words written and their XOR since start

module instr_encoder
  import isa_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count,
  output logic [31:0]       cksum
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

  enc_state_e        state;
  logic [ADDR_W-1:0] addr_ptr;
  desc_t             desc;
  logic [31:0]       word;
  logic              illegal;
  logic              accept;

  assign desc = '{op: in_op, rs: in_rs, rt: in_rt, rd: in_rd,
                  shamt: in_shamt, imm: in_imm, target: in_target};

  instr_pack u_pack (
    .desc    (desc),
    .word    (word),
    .illegal (illegal)
  );

  // start wins over a descriptor presented in the same cycle.
  assign in_ready = (state == S_LOAD) && !start;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE;
      imem_wdata <= '0;
      count      <= '0;
      addr_ptr   <= BASE;
    end else begin
      imem_we <= accept;
      if (start) begin
        state    <= S_LOAD;
        busy     <= 1'b1;
        done     <= 1'b0;
        err      <= 1'b0;
        count    <= '0;
        addr_ptr <= BASE;
      end else if (accept) begin
        imem_addr  <= addr_ptr;
        imem_wdata <= word;
        count      <= count + (ADDR_W+1)'(1);
        addr_ptr   <= addr_ptr + ADDR_W'(1);
        if (illegal) err <= 1'b1;
        // Top address ends the load so the pointer never wraps.
        if (in_last || addr_ptr == TOP_ADDR) begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

`ifdef IENC_CKSUM_EN
  logic [31:0] cksum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cksum_q <= '0;
    else if (start)  cksum_q <= '0;
    else if (accept) cksum_q <= cksum_q ^ word;
  end

  assign cksum = cksum_q;
`else
  assign cksum = '0;
`endif

endmodule
